// File: rtl/maj_pkg.sv
// Shared constants and types for the majority-vote collector and its output slot.
// The state enum is decoded from live signals and used only by assertions.
package maj_pkg;
   localparam int N_VOTES_DEF        = 32;
   localparam int COUNT_W            = 6;
   localparam int TIMEOUT_CYCLES_DEF = 64;

   typedef enum logic [1:0] {
      EMPTY,
      FILLING,
      BLOCKED
   } maj_state_e;
endpackage

// File: rtl/maj_word_slot.sv
// One-entry registered output slot with valid/ready: load, hold under backpressure, drain.
// Reusable anywhere a single word must be presented downstream.
module maj_word_slot #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_load,
   input  logic [W-1:0] i_data,
   input  logic         i_partial,
   input  logic         i_ready,
   output logic         o_valid,
   output logic [W-1:0] o_data,
   output logic         o_partial,
   output logic         o_free
);

   logic         r_valid;
   logic [W-1:0] r_data;
   logic         r_partial;

   assign o_valid   = r_valid;
   assign o_data    = r_data;
   assign o_partial = r_partial;
   assign o_free    = !r_valid || i_ready;

   // A load may coincide with a drain; the new word simply replaces the old one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid   <= 1'b0;
         r_data    <= '0;
         r_partial <= 1'b0;
      end else if (i_load) begin
         r_valid   <= 1'b1;
         r_data    <= i_data;
         r_partial <= i_partial;
      end else if (i_ready) begin
         r_valid   <= 1'b0;
      end
   end

endmodule

// File: rtl/majority_vote_collector.sv
// Serial-to-parallel vote collector: one vote per cycle in, one N_VOTES-bit word out.
// Define MAJ_COLLECT_TIMEOUT_EN to flush idle partial words after TIMEOUT_CYCLES.
module majority_vote_collector
   import maj_pkg::*;
#(
   parameter int N_VOTES        = N_VOTES_DEF,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clear,
   input  logic               vote_valid,
   input  logic               vote_bit,
   output logic               vote_ready,
   output logic [COUNT_W-1:0] vote_count,
   output logic               word_valid,
   input  logic               word_ready,
   output logic [N_VOTES-1:0] word_data,
   output logic               word_partial
);

   localparam int                 IDX_W = (N_VOTES > 1) ? $clog2(N_VOTES) : 1;
   localparam logic [COUNT_W-1:0] LAST  = COUNT_W'(N_VOTES - 1);

   if (N_VOTES < 2 || N_VOTES > 32 || TIMEOUT_CYCLES < 1) begin : g_paramCheck
      $error("majority_vote_collector: N_VOTES must be 2..32 and TIMEOUT_CYCLES >= 1");
   end

   logic [COUNT_W-1:0] r_count;
   logic [N_VOTES-1:0] r_asm;
   logic [IDX_W-1:0]   w_idx;
   logic               w_slotFree;
   logic               w_accept;
   logic               w_complete;
   logic               w_flush;
   logic               w_load;
   logic               w_loadPartial;
   logic [N_VOTES-1:0] w_loadData;
   maj_state_e         w_state;

   assign w_idx      = r_count[IDX_W-1:0];
   assign vote_ready = !clear && ((r_count < LAST) || w_slotFree);
   assign w_accept   = vote_valid && vote_ready;
   assign w_complete = w_accept && (r_count == LAST);
   assign w_load     = w_complete || w_flush;
   assign vote_count = r_count;

   // The final vote bypasses the assembly register so the word loads on the same edge.
   always_comb begin
      w_loadData = r_asm;
      if (w_complete) begin
         w_loadData[N_VOTES-1] = vote_bit;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
         r_asm   <= '0;
      end else if (clear || w_load) begin
         r_count <= '0;
         r_asm   <= '0;
      end else if (w_accept) begin
         r_count      <= r_count + COUNT_W'(1);
         r_asm[w_idx] <= vote_bit;
      end
   end

`ifdef MAJ_COLLECT_TIMEOUT_EN
   localparam int              IDLE_W   = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES);

   logic [IDLE_W-1:0] r_idle;

   assign w_flush       = (r_idle == IDLE_MAX) && w_slotFree && !w_accept && !clear
                          && (r_count != '0);
   assign w_loadPartial = w_flush;

   // Saturates at the limit so a flush blocked by backpressure fires once the slot frees.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idle <= '0;
      end else if (w_accept || clear || (r_count == '0) || w_flush) begin
         r_idle <= '0;
      end else if (r_idle != IDLE_MAX) begin
         r_idle <= r_idle + IDLE_W'(1);
      end
   end
`else
   assign w_flush       = 1'b0;
   assign w_loadPartial = 1'b0;
`endif

   maj_word_slot #(
      .W(N_VOTES)
   ) u_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_load   (w_load),
      .i_data   (w_loadData),
      .i_partial(w_loadPartial),
      .i_ready  (word_ready),
      .o_valid  (word_valid),
      .o_data   (word_data),
      .o_partial(word_partial),
      .o_free   (w_slotFree)
   );

   always_comb begin
      w_state = FILLING;
      if (r_count == '0 && !word_valid) begin
         w_state = EMPTY;
      end else if (r_count == LAST && word_valid && !word_ready) begin
         w_state = BLOCKED;
      end
   end

   a_blockedStalls: assert property (@(posedge clk) disable iff (!rst_n)
      (w_state == BLOCKED) |-> !vote_ready);
   a_countInRange: assert property (@(posedge clk) disable iff (!rst_n)
      r_count <= LAST);

endmodule

// File: tb/tb_majority_vote_collector.sv
// Self-checking bench for majority_vote_collector against a queue-based reference model.
// Timeout scenarios follow MAJ_COLLECT_TIMEOUT_EN so the bench matches either build.
module tb_majority_vote_collector;

   localparam int N   = 32;
   localparam int TMO = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         clear;
   logic         vote_valid;
   logic         vote_bit;
   logic         vote_ready;
   logic [5:0]   vote_count;
   logic         word_valid;
   logic         word_ready;
   logic [N-1:0] word_data;
   logic         word_partial;

   int errors = 0;
   int checks = 0;

   bit           mBits[$];
   bit           mWordValid;
   bit           mPartial;
   logic [N-1:0] mWordData;
   bit           mExpReady;
`ifdef MAJ_COLLECT_TIMEOUT_EN
   int           mIdle;
`endif

   always #5 clk = ~clk;

   majority_vote_collector #(
      .N_VOTES       (N),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .clear       (clear),
      .vote_valid  (vote_valid),
      .vote_bit    (vote_bit),
      .vote_ready  (vote_ready),
      .vote_count  (vote_count),
      .word_valid  (word_valid),
      .word_ready  (word_ready),
      .word_data   (word_data),
      .word_partial(word_partial)
   );

   // Reference model state mirrors the rules: a queue of accepted bits and one output word.
   task automatic modelReset();
      mBits.delete();
      mWordValid = 1'b0;
      mPartial   = 1'b0;
      mWordData  = '0;
`ifdef MAJ_COLLECT_TIMEOUT_EN
      mIdle      = 0;
`endif
   endtask

   task automatic drive(input logic c, input logic vv, input logic vb, input logic wr);
      clear      = c;
      vote_valid = vv;
      vote_bit   = vb;
      word_ready = wr;
      mExpReady  = !c && ((mBits.size() < N - 1) || !mWordValid || wr);
      #1;
   endtask

   task automatic tick();
      bit           accept;
      bit           flush;
      bit           full;
      logic [N-1:0] w;
      @(posedge clk);
      accept = vote_valid && mExpReady;
      flush  = 1'b0;
      full   = 1'b0;
      w      = '0;
`ifdef MAJ_COLLECT_TIMEOUT_EN
      flush = !accept && !clear && (mBits.size() > 0) && (mIdle == TMO)
              && (!mWordValid || word_ready);
      if (accept || clear || mBits.size() == 0 || flush) mIdle = 0;
      else if (mIdle < TMO) mIdle++;
`endif
      if (clear) mBits.delete();
      else if (accept) begin
         mBits.push_back(vote_bit);
         if (mBits.size() == N) full = 1'b1;
      end
      if (full || flush) begin
         foreach (mBits[k]) w[k] = mBits[k];
         mBits.delete();
         mWordValid = 1'b1;
         mWordData  = w;
         mPartial   = flush;
      end else if (word_ready) begin
         mWordValid = 1'b0;
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      modelReset();
      drive(0, 0, 0, 0);
      repeat (2) @(negedge clk);
      checks++; if (word_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got=%b exp=0", word_valid); end
      checks++; if (word_data !== '0) begin errors++; $display("[TB] FAIL reset_data got=%h exp=0", word_data); end
      checks++; if (vote_count !== 6'd0) begin errors++; $display("[TB] FAIL reset_count got=%0d exp=0", vote_count); end
      checks++; if (word_partial !== 1'b0) begin errors++; $display("[TB] FAIL reset_partial got=%b exp=0", word_partial); end
      checks++; if (vote_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got=%b exp=1", vote_ready); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_alternating();
      for (int i = 0; i < N; i++) begin
         drive(0, 1, (i % 2 == 0), 1);
         checks++; if (vote_ready !== 1'b1) begin errors++; $display("[TB] FAIL alt_ready i=%0d got=%b exp=1", i, vote_ready); end
         tick();
         if (i < N - 1) begin
            checks++; if (word_valid !== 1'b0) begin errors++; $display("[TB] FAIL alt_early_valid i=%0d got=%b exp=0", i, word_valid); end
         end
      end
      checks++; if (word_valid !== 1'b1) begin errors++; $display("[TB] FAIL alt_valid got=%b exp=1", word_valid); end
      checks++; if (word_data !== 32'h5555_5555) begin errors++; $display("[TB] FAIL alt_data got=%h exp=55555555", word_data); end
      checks++; if (vote_count !== 6'd0) begin errors++; $display("[TB] FAIL alt_count got=%0d exp=0", vote_count); end
      drive(0, 0, 0, 1);
      tick();
      checks++; if (word_valid !== 1'b0) begin errors++; $display("[TB] FAIL alt_pulse got=%b exp=0", word_valid); end
   endtask

   task automatic test_back_to_back();
      int seen = 0;
      for (int i = 0; i < 2 * N; i++) begin
         bit expV;
         drive(0, 1, (i < N), 1);
         checks++; if (vote_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready i=%0d got=%b exp=1", i, vote_ready); end
         tick();
         expV = (i == N - 1) || (i == 2 * N - 1);
         if (word_valid) seen++;
         checks++; if (word_valid !== expV) begin errors++; $display("[TB] FAIL b2b_valid i=%0d got=%b exp=%b", i, word_valid, expV); end
         if (i == N - 1) begin
            checks++; if (word_data !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL b2b_word1 got=%h exp=ffffffff", word_data); end
         end
         if (i == 2 * N - 1) begin
            checks++; if (word_data !== 32'h0000_0000) begin errors++; $display("[TB] FAIL b2b_word2 got=%h exp=00000000", word_data); end
         end
      end
      checks++; if (seen != 2) begin errors++; $display("[TB] FAIL b2b_words got=%0d exp=2", seen); end
      drive(0, 0, 0, 1);
      tick();
   endtask

   task automatic test_backpressure();
      logic [N-1:0] w1 = $urandom;
      logic [N-1:0] w2 = $urandom;
      for (int i = 0; i < N; i++) begin drive(0, 1, w1[i], 0); tick(); end
      checks++; if (word_valid !== 1'b1 || word_data !== w1) begin errors++; $display("[TB] FAIL bp_word1 got=%b/%h exp=1/%h", word_valid, word_data, w1); end
      for (int i = 0; i < N - 1; i++) begin
         drive(0, 1, w2[i], 0);
         checks++; if (vote_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_fill_ready i=%0d got=%b exp=1", i, vote_ready); end
         tick();
      end
      checks++; if (vote_count !== 6'd31) begin errors++; $display("[TB] FAIL bp_count got=%0d exp=31", vote_count); end
      for (int k = 0; k < 3; k++) begin
         drive(0, 1, w2[N-1], 0);
         checks++; if (vote_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_stall_ready k=%0d got=%b exp=0", k, vote_ready); end
         tick();
         checks++; if (word_valid !== 1'b1 || word_data !== w1 || vote_count !== 6'd31) begin
            errors++; $display("[TB] FAIL bp_hold k=%0d got=%b/%h/%0d exp=1/%h/31", k, word_valid, word_data, vote_count, w1);
         end
      end
      drive(0, 1, w2[N-1], 1);
      checks++; if (vote_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_release_ready got=%b exp=1", vote_ready); end
      tick();
      checks++; if (word_valid !== 1'b1 || word_data !== w2) begin errors++; $display("[TB] FAIL bp_word2 got=%b/%h exp=1/%h", word_valid, word_data, w2); end
      checks++; if (vote_count !== 6'd0) begin errors++; $display("[TB] FAIL bp_count2 got=%0d exp=0", vote_count); end
      drive(0, 0, 0, 1);
      tick();
      checks++; if (word_valid !== 1'b0 || word_data !== w2) begin errors++; $display("[TB] FAIL bp_drain got=%b/%h exp=0/%h", word_valid, word_data, w2); end
   endtask

   task automatic test_clear();
      logic [N-1:0] w1 = $urandom;
      for (int i = 0; i < N; i++) begin drive(0, 1, w1[i], 0); tick(); end
      for (int i = 0; i < 10; i++) begin drive(0, 1, 1, 0); tick(); end
      checks++; if (vote_count !== 6'd10) begin errors++; $display("[TB] FAIL clr_pre_count got=%0d exp=10", vote_count); end
      drive(1, 1, 1, 0);
      checks++; if (vote_ready !== 1'b0) begin errors++; $display("[TB] FAIL clr_ready got=%b exp=0", vote_ready); end
      tick();
      checks++; if (vote_count !== 6'd0) begin errors++; $display("[TB] FAIL clr_count got=%0d exp=0", vote_count); end
      checks++; if (word_valid !== 1'b1 || word_data !== w1) begin errors++; $display("[TB] FAIL clr_slot got=%b/%h exp=1/%h", word_valid, word_data, w1); end
      for (int i = 0; i < N; i++) begin drive(0, 1, 0, (i == N - 1)); tick(); end
      checks++; if (word_valid !== 1'b1 || word_data !== '0) begin errors++; $display("[TB] FAIL clr_after got=%b/%h exp=1/00000000", word_valid, word_data); end
      drive(0, 0, 0, 1);
      tick();
   endtask

   task automatic test_timeout();
      for (int i = 0; i < 5; i++) begin drive(0, 1, 1, 1); tick(); end
`ifdef MAJ_COLLECT_TIMEOUT_EN
      begin
         int waited = 0;
         while (!word_valid && waited < TMO + 4) begin drive(0, 0, 0, 0); tick(); waited++; end
         checks++; if (word_valid !== 1'b1) begin errors++; $display("[TB] FAIL tmo_valid got=%b exp=1 after %0d cycles", word_valid, waited); end
         checks++; if (waited < TMO || waited > TMO + 1) begin errors++; $display("[TB] FAIL tmo_latency got=%0d exp=%0d..%0d", waited, TMO, TMO + 1); end
         checks++; if (word_data !== 32'h0000_001F || word_partial !== 1'b1) begin errors++; $display("[TB] FAIL tmo_word got=%h/%b exp=0000001f/1", word_data, word_partial); end
         checks++; if (vote_count !== 6'd0) begin errors++; $display("[TB] FAIL tmo_count got=%0d exp=0", vote_count); end
         drive(0, 0, 0, 1);
         tick();
      end
`else
      repeat (3 * TMO) begin drive(0, 0, 0, 0); tick(); end
      checks++; if (word_valid !== 1'b0) begin errors++; $display("[TB] FAIL notmo_valid got=%b exp=0", word_valid); end
      checks++; if (vote_count !== 6'd5) begin errors++; $display("[TB] FAIL notmo_count got=%0d exp=5", vote_count); end
      checks++; if (word_partial !== 1'b0) begin errors++; $display("[TB] FAIL notmo_partial got=%b exp=0", word_partial); end
      drive(1, 0, 0, 0);
      tick();
`endif
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < N; i++) begin drive(0, 1, 1, 0); tick(); end
      for (int i = 0; i < 17; i++) begin drive(0, 1, 1, 0); tick(); end
      checks++; if (vote_count !== 6'd17 || word_valid !== 1'b1) begin errors++; $display("[TB] FAIL ar_pre got=%0d/%b exp=17/1", vote_count, word_valid); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (word_valid !== 1'b0 || word_data !== '0) begin errors++; $display("[TB] FAIL ar_slot got=%b/%h exp=0/0", word_valid, word_data); end
      checks++; if (vote_count !== 6'd0 || word_partial !== 1'b0) begin errors++; $display("[TB] FAIL ar_count got=%0d/%b exp=0/0", vote_count, word_partial); end
      modelReset();
      drive(0, 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         drive(($urandom % 16) == 0, ($urandom % 4) != 0, 1'($urandom % 2), ($urandom % 3) != 0);
         checks++; if (vote_ready !== mExpReady) begin errors++; $display("[TB] FAIL rnd_ready i=%0d got=%b exp=%b", i, vote_ready, mExpReady); end
         tick();
         checks++; if (word_valid !== mWordValid) begin errors++; $display("[TB] FAIL rnd_valid i=%0d got=%b exp=%b", i, word_valid, mWordValid); end
         checks++; if (word_data !== mWordData) begin errors++; $display("[TB] FAIL rnd_data i=%0d got=%h exp=%h", i, word_data, mWordData); end
         checks++; if (vote_count !== 6'(mBits.size())) begin errors++; $display("[TB] FAIL rnd_count i=%0d got=%0d exp=%0d", i, vote_count, mBits.size()); end
         checks++; if (word_partial !== mPartial) begin errors++; $display("[TB] FAIL rnd_partial i=%0d got=%b exp=%b", i, word_partial, mPartial); end
      end
   endtask

   initial begin
      test_reset();
      test_alternating();
      test_back_to_back();
      test_backpressure();
      test_clear();
      test_timeout();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
